// File: rtl/mem_port_arb.sv
// Two-requester memory port arbiter: icache refill and dcache refill/write-back
// share one memory port, alternating on contention, with protocol checking.
module mem_port_arb #(
  parameter int BEATS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_req,
  input  logic [19:0]  i_addr,
  output logic [31:0]  i_rdata,
  output logic         i_valid,
  output logic         i_rd_done,
  input  logic         d_req,
  input  logic         d_wr,
  input  logic [19:0]  d_addr,
  input  logic [127:0] d_wdata,
  output logic [31:0]  d_rdata,
  output logic         d_valid,
  output logic         d_rd_done,
  output logic         d_wr_done,
  output logic         mem_req,
  output logic         mem_wr,
  output logic [19:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_valid,
  input  logic         mem_rd_done,
  input  logic         mem_wr_done,
  output logic [1:0]   owner,
  output logic         arb_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam int CW = $clog2(BEATS + 1);
  localparam logic [CW-1:0] FULL = CW'(BEATS);

  state_t        state;
  state_t        state_nx;
  logic          last_d;
  logic [CW-1:0] cnt;
  logic          in_gnt;
  logic          grant;
  logic          rd_ok;
  logic          err_now;

  assign in_gnt = (state != IDLE);
  assign grant  = (state == IDLE) && (state_nx != IDLE);

  // A read done is only legitimate in a read grant after a full line.
  assign rd_ok = in_gnt && mem_rd_done && !mem_wr && (cnt == FULL);

  // Protocol violations seen on the memory side this cycle.
  always_comb begin
    err_now = 1'b0;
    if (in_gnt) begin
      if (mem_rd_done && (mem_wr || cnt != FULL)) err_now = 1'b1;
      if (mem_wr_done && !mem_wr)                 err_now = 1'b1;
      if (mem_valid && mem_wr)                    err_now = 1'b1;
    end else begin
      if (mem_valid || mem_rd_done || mem_wr_done) err_now = 1'b1;
    end
  end

  // Next-state: alternate on contention, release on any done.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (i_req && (!d_req || last_d)) state_nx = GNT_I;
        else if (d_req)                  state_nx = GNT_D;
      end
      GNT_I, GNT_D: begin
        if (mem_rd_done || mem_wr_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, latched request, beat counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= 2'b00;
      arb_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        last_d  <= (state_nx == GNT_D);
        cnt     <= '0;
        mem_req <= 1'b1;
        if (state_nx == GNT_D) begin
          owner     <= 2'b10;
          mem_wr    <= d_wr;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else begin
          owner     <= 2'b01;
          mem_wr    <= 1'b0;
          mem_addr  <= i_addr;
          mem_wdata <= '0;
        end
      end else if (in_gnt && state_nx == IDLE) begin
        mem_req <= 1'b0;
        owner   <= 2'b00;
      end
      if (in_gnt && !mem_wr && mem_valid && cnt != FULL) begin
        cnt <= cnt + 1'b1;
      end
      if (err_now) arb_err <= 1'b1;
    end
  end

  assign i_rdata   = reset ? '0 : mem_rdata;
  assign d_rdata   = reset ? '0 : mem_rdata;
  assign i_valid   = !reset && (state == GNT_I) && mem_valid;
  assign d_valid   = !reset && (state == GNT_D) && mem_valid;
  assign i_rd_done = !reset && (state == GNT_I) && rd_ok;
  assign d_rd_done = !reset && (state == GNT_D) && rd_ok;
  assign d_wr_done = !reset && (state == GNT_D) && mem_wr
                     && mem_wr_done;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed testbench for mem_port_arb.
// Each scenario task drives stimulus and checks results inline.
module tb_mem_port_arb;

  logic         clk;
  logic         reset;
  logic         i_req;
  logic [19:0]  i_addr;
  logic [31:0]  i_rdata;
  logic         i_valid;
  logic         i_rd_done;
  logic         d_req;
  logic         d_wr;
  logic [19:0]  d_addr;
  logic [127:0] d_wdata;
  logic [31:0]  d_rdata;
  logic         d_valid;
  logic         d_rd_done;
  logic         d_wr_done;
  logic         mem_req;
  logic         mem_wr;
  logic [19:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_valid;
  logic         mem_rd_done;
  logic         mem_wr_done;
  logic [1:0]   owner;
  logic         arb_err;

  int nvec = 0;
  int nerr = 0;

  mem_port_arb #(.BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_valid(i_valid), .i_rd_done(i_rd_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_rd_done(d_rd_done),
    .d_wr_done(d_wr_done),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .mem_rd_done(mem_rd_done), .mem_wr_done(mem_wr_done),
    .owner(owner), .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Status bundle: {mem_req, mem_wr, owner, arb_err}.
  function automatic logic [4:0] st();
    return {mem_req, mem_wr, owner, arb_err};
  endfunction

  // Forwarded strobes: {i_valid, i_rd_done, d_valid, d_rd_done, d_wr_done}.
  function automatic logic [4:0] fw();
    return {i_valid, i_rd_done, d_valid, d_rd_done, d_wr_done};
  endfunction

  // Feed n read beats without checking (used to complete grants).
  task automatic feed(input int n);
    for (int k = 0; k < n; k++) begin
      mem_valid = 1'b1;
      mem_rdata = 32'h5500_0000 + k;
      tick();
    end
    mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    nvec++;
    if (st() !== 5'b0_0_00_0) begin
      nerr++;
      $display("FAIL reset_status got %b want %b", st(), 5'b0);
    end
    nvec++;
    if ({mem_addr, mem_wdata} !== '0) begin
      nerr++;
      $display("FAIL reset_bus got %h/%h want 0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_icache_read();
    int nv;
    i_req  = 1'b1;
    i_addr = 20'h00A40;
    tick();
    nvec++;
    if ({st(), mem_addr} !== {5'b1_0_01_0, 20'h00A40}) begin
      nerr++;
      $display("FAIL i_grant got %b/%h want 10010/00a40", st(), mem_addr);
    end
    nv = 0;
    for (int k = 0; k < 4; k++) begin
      mem_valid = 1'b1;
      mem_rdata = 32'hC0DE_0000 + k;
      #1;
      if (i_valid === 1'b1 && d_valid === 1'b0
          && i_rdata === 32'hC0DE_0000 + k) nv++;
      tick();
    end
    mem_valid = 1'b0;
    nvec++;
    if (nv !== 4) begin
      nerr++;
      $display("FAIL i_beats got %0d want 4", nv);
    end
    mem_rd_done = 1'b1;
    #1;
    nvec++;
    if (fw() !== 5'b01000) begin
      nerr++;
      $display("FAIL i_done got %b want 01000", fw());
    end
    tick();
    mem_rd_done = 1'b0;
    i_req = 1'b0;
    #1;
    nvec++;
    if (st() !== 5'b0_0_00_0) begin
      nerr++;
      $display("FAIL i_release got %b want 00000", st());
    end
  endtask

  task automatic test_simultaneous();
    i_req  = 1'b1;
    i_addr = 20'h00100;
    d_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 20'h0D200;
    tick();
    nvec++;
    if ({st(), mem_addr} !== {5'b1_0_10_0, 20'h0D200}) begin
      nerr++;
      $display("FAIL sim_d_first got %b/%h want 10100/0d200", st(), mem_addr);
    end
    mem_valid = 1'b1;
    #1;
    nvec++;
    if (fw() !== 5'b00100) begin
      nerr++;
      $display("FAIL sim_d_valid got %b want 00100", fw());
    end
    tick();
    feed(3);
    mem_rd_done = 1'b1;
    #1;
    nvec++;
    if (fw() !== 5'b00010) begin
      nerr++;
      $display("FAIL sim_d_done got %b want 00010", fw());
    end
    tick();
    mem_rd_done = 1'b0;
    d_req = 1'b0;
    #1;
    nvec++;
    if (st() !== 5'b0_0_00_0) begin
      nerr++;
      $display("FAIL sim_gap got %b want 00000", st());
    end
    tick();
    nvec++;
    if ({st(), mem_addr} !== {5'b1_0_01_0, 20'h00100}) begin
      nerr++;
      $display("FAIL sim_i_next got %b/%h want 10010/00100", st(), mem_addr);
    end
    feed(4);
    mem_rd_done = 1'b1;
    tick();
    mem_rd_done = 1'b0;
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_dcache_wb();
    d_req   = 1'b1;
    d_wr    = 1'b1;
    d_addr  = 20'h1F000;
    d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    tick();
    nvec++;
    if ({st(), mem_addr} !== {5'b1_1_10_0, 20'h1F000}) begin
      nerr++;
      $display("FAIL wb_grant got %b/%h want 11100/1f000", st(), mem_addr);
    end
    nvec++;
    if (mem_wdata !== 128'h0123456789ABCDEF0123456789ABCDEF) begin
      nerr++;
      $display("FAIL wb_wdata got %h want 0123..cdef", mem_wdata);
    end
    mem_wr_done = 1'b1;
    #1;
    nvec++;
    if (fw() !== 5'b00001) begin
      nerr++;
      $display("FAIL wb_done got %b want 00001", fw());
    end
    tick();
    mem_wr_done = 1'b0;
    d_req = 1'b0;
    d_wr  = 1'b0;
    #1;
    nvec++;
    if (st() !== 5'b0_1_00_0) begin
      nerr++;
      $display("FAIL wb_release got %b want 01000", st());
    end
  endtask

  task automatic test_back_to_back();
    i_req  = 1'b1;
    i_addr = 20'h00300;
    d_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 20'h0D400;
    tick();
    nvec++;
    if ({st(), mem_addr} !== {5'b1_0_01_0, 20'h00300}) begin
      nerr++;
      $display("FAIL b2b_i_first got %b/%h want 10010/00300", st(), mem_addr);
    end
    nvec++;
    if (mem_wdata !== '0) begin
      nerr++;
      $display("FAIL b2b_i_wdata got %h want 0", mem_wdata);
    end
    feed(4);
    mem_rd_done = 1'b1;
    tick();
    mem_rd_done = 1'b0;
    i_req = 1'b0;
    tick();
    nvec++;
    if ({st(), mem_addr} !== {5'b1_0_10_0, 20'h0D400}) begin
      nerr++;
      $display("FAIL b2b_d_second got %b/%h want 10100/0d400", st(), mem_addr);
    end
    feed(4);
    mem_rd_done = 1'b1;
    tick();
    mem_rd_done = 1'b0;
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_short_read();
    i_req  = 1'b1;
    i_addr = 20'h00500;
    tick();
    feed(3);
    mem_rd_done = 1'b1;
    #1;
    nvec++;
    if (fw() !== 5'b00000) begin
      nerr++;
      $display("FAIL short_fwd got %b want 00000", fw());
    end
    tick();
    mem_rd_done = 1'b0;
    i_req = 1'b0;
    #1;
    nvec++;
    if (st() !== 5'b0_0_00_1) begin
      nerr++;
      $display("FAIL short_err got %b want 00001", st());
    end
    tick();
    tick();
    nvec++;
    if (arb_err !== 1'b1) begin
      nerr++;
      $display("FAIL short_sticky got %b want 1", arb_err);
    end
  endtask

  task automatic test_reset_mid();
    d_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 20'h0E000;
    tick();
    feed(2);
    reset       = 1'b1;
    mem_valid   = 1'b1;
    mem_rd_done = 1'b1;
    #1;
    nvec++;
    if ({fw(), d_rdata} !== {5'b0, 32'h0}) begin
      nerr++;
      $display("FAIL rst_gate got %b/%h want 00000/0", fw(), d_rdata);
    end
    tick();
    reset       = 1'b0;
    mem_valid   = 1'b0;
    mem_rd_done = 1'b0;
    #1;
    nvec++;
    if (st() !== 5'b0_0_00_0) begin
      nerr++;
      $display("FAIL rst_mid got %b want 00000", st());
    end
    tick();
    nvec++;
    if ({st(), mem_addr} !== {5'b1_0_10_0, 20'h0E000}) begin
      nerr++;
      $display("FAIL rst_regrant got %b/%h want 10100/0e000", st(), mem_addr);
    end
    feed(4);
    mem_rd_done = 1'b1;
    #1;
    nvec++;
    if (fw() !== 5'b00010) begin
      nerr++;
      $display("FAIL rst_done got %b want 00010", fw());
    end
    tick();
    mem_rd_done = 1'b0;
    d_req = 1'b0;
    #1;
    nvec++;
    if (st() !== 5'b0_0_00_0) begin
      nerr++;
      $display("FAIL rst_clean got %b want 00000", st());
    end
  endtask

  task automatic test_stray_valid();
    tick();
    mem_valid = 1'b1;
    #1;
    nvec++;
    if (fw() !== 5'b00000) begin
      nerr++;
      $display("FAIL stray_fwd got %b want 00000", fw());
    end
    tick();
    mem_valid = 1'b0;
    #1;
    nvec++;
    if (st() !== 5'b0_0_00_1) begin
      nerr++;
      $display("FAIL stray_err got %b want 00001", st());
    end
  endtask

  initial begin
    reset       = 1'b1;
    i_req       = 1'b0;
    i_addr      = '0;
    d_req       = 1'b0;
    d_wr        = 1'b0;
    d_addr      = '0;
    d_wdata     = '0;
    mem_rdata   = '0;
    mem_valid   = 1'b0;
    mem_rd_done = 1'b0;
    mem_wr_done = 1'b0;
    test_reset();
    test_icache_read();
    test_simultaneous();
    test_dcache_wb();
    test_back_to_back();
    test_short_read();
    test_reset_mid();
    test_stray_valid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports: clk  in  1  clock; reset  in  1  sync active-high reset.
REQ-003 SHALL have ports: i_req  in  1 / i_addr  in  20 / i_rdata  out  32 / i_valid  out  1 / i_rd_done  out  1. These form the icache refill port, which is read-only.
REQ-004 SHALL have ports: d_req  in  1 / d_wr  in  1 / d_addr  in  20 / d_wdata  in  128 / d_rdata  out  32 / d_valid  out  1 / d_rd_done  out  1 / d_wr_done  out  1. These form the dcache refill and write-back port.
REQ-005 SHALL have memory-side ports: mem_req  out  1 / mem_wr  out  1 / mem_addr  out  20 / mem_wdata  out  128 / mem_rdata  in  32 / mem_valid  in  1 / mem_rd_done  in  1 / mem_wr_done  in  1.
REQ-006 SHALL have status ports: owner  out  2 (00 none, 01 icache, 10 dcache); arb_err  out  1 (sticky protocol error).
REQ-007 SHALL have parameter BEATS, default 4, meaning the number of 32-bit mem_valid beats per line read.

Function
REQ-008 Requester protocol: a requester SHALL hold req, addr, wr and wdata stable until its done pulse, then drop req no later than the following cycle.
REQ-009 FSM states SHALL be IDLE, GNT_I, GNT_D.
- IDLE→GNT_I: i_req and (not d_req, or last grant was D).
- IDLE→GNT_D: d_req and (not i_req, or last grant was I).
- GNT_x→IDLE: on the cycle mem_rd_done or mem_wr_done is sampled high.
REQ-010 The last-grant pointer SHALL update on each IDLE→GNT transition and reset to I, so dcache wins the first simultaneous request.
REQ-011 On the IDLE→GNT edge, the owner's addr, wr and wdata SHALL be latched into mem_addr, mem_wr and mem_wdata.
- mem_req SHALL be registered, high from the first GNT cycle until the done cycle inclusive.
- Latency from req sampled in IDLE to mem_req high: 1 cycle.
REQ-012 For an icache grant, mem_wr SHALL be 0 and mem_wdata SHALL be 0.
REQ-013 mem_rdata SHALL route combinationally to both i_rdata and d_rdata.
- i_valid = mem_valid while in GNT_I.
- d_valid = mem_valid while in GNT_D.
REQ-014 Done forwarding SHALL be combinational, same cycle as the mem input, to the current owner only.
- i_rd_done = mem_rd_done in GNT_I.
- d_rd_done = mem_rd_done in GNT_D with latched wr=0.
- d_wr_done = mem_wr_done in GNT_D with latched wr=1.
REQ-015 There SHALL be a minimum of one IDLE cycle (mem_req low) between consecutive grants.
REQ-016 A beat counter (width clog2(BEATS+1)) SHALL behave as follows:
- cleared on every grant;
- incremented on mem_valid in a read grant;
- saturates at BEATS.
REQ-017 arb_err SHALL set, and stay set until reset, on any of:
- mem_rd_done with beat count ≠ BEATS;
- mem_rd_done during a write grant;
- mem_wr_done during a read grant;
- mem_valid during a write grant or in IDLE;
- any done input in IDLE.
REQ-018 A mismatched done (REQ-017) SHALL still end the grant and return the FSM to IDLE, but SHALL NOT be forwarded to the requester.
REQ-019 mem_valid or done inputs in IDLE SHALL be ignored except for setting arb_err.
REQ-020 Request changes during a grant SHALL be ignored; the latched values govern the grant.
REQ-021 owner SHALL be 00 in IDLE, 01 in GNT_I, 10 in GNT_D, and SHALL be registered.

Reset
REQ-022 Reset SHALL force, on the next edge: state IDLE, mem_req 0, mem_wr 0, mem_addr 0, mem_wdata 0, owner 00, arb_err 0, beat count 0, last grant I.
REQ-023 Reset asserted mid-grant SHALL abandon the transfer with no done forwarded; mem_req SHALL be low on the cycle after the reset edge.
REQ-024 Combinational outputs (i_/d_ valid, done, rdata) SHALL be 0 while reset is high.

Verification
REQ-025 The bench SHALL cover:
- Lone icache read: i_req=1, i_addr=20'h00A40. Expect mem_req=1 and mem_addr=20'h00A40 one cycle later, mem_wr=0. Send 4 mem_valid beats, then mem_rd_done. Expect i_valid×4, i_rd_done, owner 01→00, arb_err=0.
- Simultaneous first request: i_req and d_req high in the same cycle after reset. Expect dcache granted first. After d done, expect one idle cycle, then icache granted. A second simultaneous pair is granted icache-first if the last grant was D.
- Dcache write-back: d_wr=1, d_wdata=128'h0123…CDEF, d_addr=20'h1F000. Expect mem_wr=1 and mem_wdata matching. mem_wr_done produces d_wr_done only; i_* and d_rd_done stay 0.
- Short read: 3 beats then mem_rd_done. Expect arb_err=1 (sticky), no forwarded done, FSM in IDLE next cycle.
- Reset mid-grant: reset after 2 beats. Expect mem_req=0, owner=00, arb_err=0 next cycle. A subsequent d_req is served normally.
- Stray mem_valid in IDLE: expect arb_err=1, with no i_valid and no d_valid.
